buffer_controller: RTL
======================

BUFFER_CONTROLLER -- requirements
Module: buffer_controller

Interface
REQ-001 Parameter: SIZE, 16, buffer depth in words; SHALL be a power of two and SHALL satisfy SIZE >= K+J.
REQ-002 Parameter: K, 4, words written per accepted input beat.
REQ-003 Parameter: J, 8, words read per accepted output beat.
REQ-004 Ports: clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Ports: rst  in  1  synchronous, active-high reset.
REQ-006 Ports: start  in  1  pulse; moves IDLE->RUN.
REQ-007 Ports: stop  in  1  pulse; requests drain, RUN->DRAIN.
REQ-008 Ports: in_valid  in  1  producer has K words on the buffer's par_in.
REQ-009 Ports: in_ready  out  1  controller accepts the input beat this cycle.
REQ-010 Ports: out_valid  out  1  J words are available on the buffer's par_out.
REQ-011 Ports: out_ready  in  1  consumer takes the output beat this cycle.
REQ-012 Ports: ld  out  1  buffer write enable; equals in_valid & in_ready.
REQ-013 Ports: write_add  out  $clog2(SIZE)  buffer write base pointer.
REQ-014 Ports: read_add  out  $clog2(SIZE)  buffer read base pointer.
REQ-015 Ports: busy  out  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and DRAIN.
REQ-017 IDLE->RUN on start; RUN->DRAIN on stop; DRAIN->IDLE in the first cycle that count < J after any pop; start in RUN or DRAIN is ignored; stop in IDLE is ignored.
REQ-018 count SHALL be held in a $clog2(SIZE)+1-bit register giving the occupied words.
REQ-019 in_ready SHALL be (state==RUN) && (SIZE-count >= K), combinational from registers only and independent of in_valid.
REQ-020 out_valid SHALL be (state!=IDLE) && (count >= J).
REQ-021 A push (in_valid&in_ready) SHALL advance write_add by K modulo SIZE at the next edge.
REQ-022 A pop (out_valid&out_ready) SHALL advance read_add by J modulo SIZE at the next edge.
REQ-023 Next count SHALL be count + K*push - J*pop; a simultaneous push and pop SHALL both take effect in the same cycle.
REQ-024 The FSM SHALL NOT generate overflow or underflow; count SHALL stay within 0..SIZE.
REQ-025 ld SHALL have zero-cycle latency; written data SHALL be poppable from the cycle after count reaches J.
REQ-026 A residue of fewer than J words SHALL be discarded on the DRAIN->IDLE transition: count is cleared and read_add is set equal to write_add.

Reset
REQ-027 While rst is high at an edge: state=IDLE, count=0, write_add=0, read_add=0; hence in_ready=0, out_valid=0, ld=0, busy=0.
REQ-028 rst SHALL override start, stop and all handshakes in the same cycle, including in the middle of a drain.

Configuration
REQ-029 With BUFFER_CTRL_OCCUPANCY_EN defined, an extra output port occupancy [$clog2(SIZE):0] SHALL mirror count; it SHALL be 0 on reset.
REQ-030 Without BUFFER_CTRL_OCCUPANCY_EN, the occupancy port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-031 The state encoding (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2) and the default SIZE/K/J constants SHALL reside in a shared package, buffer_pkg.
REQ-032 The modulo pointer advance SHALL be a single sub-module, ptr_advance (parameters SIZE and STEP), instantiated once for write_add and once for read_add.
REQ-033 The block SHALL drive the ld, write_add and read_add ports of the existing Buffer directly, without extra registers.

Verification (SIZE=16, K=4, J=8)
REQ-034 rst for 2 cycles, then start -> in_ready=1, out_valid=0, busy=1, pointers at 0.
REQ-035 2 pushes, no pop -> count=8, write_add=8, out_valid=1; 1 pop -> read_add=8, count=0, out_valid=0.
REQ-036 4 pushes with out_ready=0 -> count=16, in_ready=0; a 5th in_valid gets no ld and write_add stays 0 after the wrap from 12.
REQ-037 At count=8, push and pop in the same cycle -> count=4, write_add+4, read_add+8 (mod 16).
REQ-038 At count=12 in RUN, stop -> DRAIN with in_ready=0; 1 pop leaves count=4 -> IDLE, count=0, read_add==write_add.
REQ-039 rst asserted during DRAIN with count=12 -> next cycle IDLE, all outputs at their reset values.

Source files
------------

// File: rtl/buffer_pkg.sv
// Shared FSM encoding and default geometry for the buffer controller.
package buffer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_SIZE = 16;
    localparam int DEF_K    = 4;
    localparam int DEF_J    = 8;

endpackage

// File: rtl/ptr_advance.sv
// Modulo-SIZE pointer step: ptr_o = ptr_i + STEP when en_i, else ptr_i.
module ptr_advance #(
    parameter int SIZE = 16,
    parameter int STEP = 4
) (
    input  logic [$clog2(SIZE)-1:0] ptr_i,
    input  logic                    en_i,
    output logic [$clog2(SIZE)-1:0] ptr_o
);

    localparam int AW = $clog2(SIZE);

    // SIZE is a power of two, so truncation to AW bits is the modulo wrap.
    always_comb begin
        if (en_i) begin
            ptr_o = ptr_i + AW'(STEP);
        end else begin
            ptr_o = ptr_i;
        end
    end

endmodule

// File: rtl/buffer_controller.sv
// Pointer/occupancy controller for a K-in / J-out word buffer.
// Optional occupancy output enabled by defining BUFFER_CTRL_OCCUPANCY_EN.
module buffer_controller
    import buffer_pkg::*;
#(
    parameter int SIZE = DEF_SIZE,
    parameter int K    = DEF_K,
    parameter int J    = DEF_J
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    ld,
    output logic [$clog2(SIZE)-1:0] write_add,
    output logic [$clog2(SIZE)-1:0] read_add,
    output logic                    busy
`ifdef BUFFER_CTRL_OCCUPANCY_EN
    ,
    output logic [$clog2(SIZE):0]   occupancy
`endif
);

    localparam int AW = $clog2(SIZE);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] PUSH_LIMIT = CW'(SIZE - K);

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   write_q, write_d;
    logic [AW-1:0]   read_q, read_d;
    logic [AW-1:0]   rd_next_s;
    logic [CW-1:0]   cnt_next_s;
    logic            push_s;
    logic            pop_s;

    assign in_ready  = (state_q == RUN) && (count_q <= PUSH_LIMIT);
    assign out_valid = (state_q != IDLE) && (count_q >= CW'(J));
    assign push_s    = in_valid & in_ready;
    assign pop_s     = out_valid & out_ready;
    assign ld        = push_s;
    assign write_add = write_q;
    assign read_add  = read_q;
    assign busy      = (state_q != IDLE);

    assign cnt_next_s = count_q + (push_s ? CW'(K) : CW'(0)) - (pop_s ? CW'(J) : CW'(0));

    ptr_advance #(.SIZE(SIZE), .STEP(K)) u_wr_adv (
        .ptr_i (write_q),
        .en_i  (push_s),
        .ptr_o (write_d)
    );

    ptr_advance #(.SIZE(SIZE), .STEP(J)) u_rd_adv (
        .ptr_i (read_q),
        .en_i  (pop_s),
        .ptr_o (rd_next_s)
    );

    // Next-state, occupancy and read-pointer selection; drain exit flushes the residue.
    always_comb begin
        state_d = state_q;
        count_d = cnt_next_s;
        read_d  = rd_next_s;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = DRAIN;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (cnt_next_s < CW'(J)) begin
                    state_d = IDLE;
                    count_d = CW'(0);
                    read_d  = write_d;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = CW'(0);
                read_d  = write_d;
            end
        endcase
    end

    // State, occupancy and pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= CW'(0);
            write_q <= AW'(0);
            read_q  <= AW'(0);
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            write_q <= write_d;
            read_q  <= read_d;
        end
    end

`ifdef BUFFER_CTRL_OCCUPANCY_EN
    assign occupancy = count_q;
`endif

endmodule
